// File: rtl/sipo_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
// The PARITY state is only reached in builds with SIPO_PARITY_EN defined.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } sipo_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/sipo_shift_core.sv
// LSB-first shift register: each shift moves the word right and inserts the
// new bit at the MSB, so the first bit received ends up in bit 0.
module sipo_shift_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] word
);

  always_ff @(posedge clk) begin
    if (clear) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {serial_in, word[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver with a one-word valid/ready holding register.
// Define SIPO_PARITY_EN to add an even-parity bit and the parity_err port.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit
// DATA   | shifting in DATA_W data bits, LSB first
// PARITY | sampling the even-parity bit (SIPO_PARITY_EN only)
// STOP   | sampling the stop bit, then deliver or discard the word
module sipo_frame_receiver
  import sipo_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
`ifdef SIPO_PARITY_EN
  output logic              parity_err,
`endif
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  sipo_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] word;
  logic              shift_en;
  logic              clear;
  logic              deliver;
  logic              stop_bad;
`ifdef SIPO_PARITY_EN
  logic              par_bad, par_bad_next;
  logic              par_fail;
`endif

  sipo_shift_core #(.DATA_W(DATA_W)) u_shift (
    .clk       (clk),
    .clear     (clear),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .word      (word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
`ifdef SIPO_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
`ifdef SIPO_PARITY_EN
      par_bad <= par_bad_next;
`endif
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shift_en     = 1'b0;
    clear        = !rst;
    deliver      = 1'b0;
    stop_bad     = 1'b0;
`ifdef SIPO_PARITY_EN
    par_bad_next = par_bad;
    par_fail     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (serial_in == LINE_START) begin
          state_next   = DATA;
          cnt_next     = '0;
          clear        = 1'b1;
`ifdef SIPO_PARITY_EN
          par_bad_next = 1'b0;
`endif
        end
      end
      DATA: begin
        shift_en = 1'b1;
        // Counter holds at its terminal value; it is cleared by the next start bit.
        if (cnt == CNT_LAST) begin
`ifdef SIPO_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        par_bad_next = serial_in != (^word);
        state_next   = STOP;
      end
`endif
      STOP: begin
        state_next = IDLE;
        if (serial_in != LINE_STOP) begin
          stop_bad = 1'b1;
`ifdef SIPO_PARITY_EN
        end else if (par_bad) begin
          par_fail = 1'b1;
`endif
        end else begin
          deliver = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver && data_valid && !data_ready;
`ifdef SIPO_PARITY_EN
      parity_err <= par_fail;
`endif
      // A word leaving on this edge frees the register for the incoming one.
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver; parity scenario runs only when
// SIPO_PARITY_EN is defined.
module tb_sipo_frame_receiver;
  import sipo_rx_pkg::*;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              serial_in = 1'b1;
  logic              data_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              busy;
  logic              frame_err;
  logic              overrun;
`ifdef SIPO_PARITY_EN
  logic              parity_err;
`endif

  int vec  = 0;
  int errs = 0;
  int valid_seen = 0;
  int ovr_seen   = 0;
  int ferr_seen  = 0;

  sipo_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
`ifdef SIPO_PARITY_EN
    .parity_err (parity_err),
`endif
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid === 1'b1) valid_seen++;
    if (overrun === 1'b1) ovr_seen++;
    if (frame_err === 1'b1) ferr_seen++;
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_body(input logic [7:0] d, input logic stop_b, input logic par_flip);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
`ifdef SIPO_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    send_bit(stop_b);
    serial_in = LINE_IDLE;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(LINE_START);
    send_body(d, stop_b, 1'b0);
  endtask

  task automatic test_reset;
    logic [11:0] obs;
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    obs = {data_out, data_valid, busy, frame_err, overrun};
    vec++;
    if (obs !== 12'h000) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected 000", obs);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1);
      obs = {data_out, data_valid, busy, frame_err, overrun};
      vec++;
      if (obs !== 12'h000) begin
        errs++;
        $display("FAIL idle_outputs cycle %0d: got %h expected 000", i, obs);
      end
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] d;
    int busy_n;
    d = 8'hA5;
    busy_n = 0;
    data_ready = 1'b0;
    send_bit(LINE_START);
    if (busy) busy_n++;
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(d[i]);
      if (busy) busy_n++;
    end
    send_bit(LINE_STOP);
    if (busy) busy_n++;
    serial_in = LINE_IDLE;
    vec++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL single_word: got %h/%b expected a5/1", data_out, data_valid);
    end
    vec++;
    if (busy_n != 9) begin
      errs++;
      $display("FAIL single_busy_cycles: got %0d expected 9", busy_n);
    end
    vec++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL single_flags: got %b%b expected 00", frame_err, overrun);
    end
    send_bit(1'b1);
    vec++;
    if (data_out !== 8'hA5 || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL single_hold: got %h/%b expected a5/1", data_out, data_valid);
    end
    data_ready = 1'b1;
    send_bit(1'b1);
    vec++;
    if (data_valid !== 1'b0) begin
      errs++;
      $display("FAIL single_accept: valid got %b expected 0", data_valid);
    end
    data_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int v0, o0;
    v0 = valid_seen;
    o0 = ovr_seen;
    data_ready = 1'b1;
    send_frame(8'h3C, 1'b1);
    vec++;
    if (data_out !== 8'h3C || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: got %h/%b expected 3c/1", data_out, data_valid);
    end
    send_bit(LINE_START);
    vec++;
    if (data_valid !== 1'b0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL b2b_gap: valid/busy got %b/%b expected 0/1", data_valid, busy);
    end
    send_body(8'hFF, 1'b1, 1'b0);
    vec++;
    if (data_out !== 8'hFF || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second: got %h/%b expected ff/1", data_out, data_valid);
    end
    send_bit(1'b1);
    vec++;
    if (valid_seen - v0 != 2 || data_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_valid_cycles: got %0d expected 2", valid_seen - v0);
    end
    vec++;
    if (ovr_seen != o0) begin
      errs++;
      $display("FAIL b2b_overrun: got %0d pulses expected 0", ovr_seen - o0);
    end
    data_ready = 1'b0;
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_seen;
    data_ready = 1'b0;
    send_frame(8'h12, 1'b1);
    vec++;
    if (data_out !== 8'h12 || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL ovr_first: got %h/%b expected 12/1", data_out, data_valid);
    end
    send_bit(1'b1);
    send_frame(8'h34, 1'b1);
    vec++;
    if (overrun !== 1'b1 || data_out !== 8'h12 || data_valid !== 1'b1) begin
      errs++;
      $display("FAIL ovr_pulse: got ovr=%b data=%h valid=%b expected 1/12/1",
               overrun, data_out, data_valid);
    end
    send_bit(1'b1);
    vec++;
    if (overrun !== 1'b0 || ovr_seen - o0 != 1 || data_out !== 8'h12) begin
      errs++;
      $display("FAIL ovr_once: got ovr=%b pulses=%0d data=%h expected 0/1/12",
               overrun, ovr_seen - o0, data_out);
    end
    data_ready = 1'b1;
    send_bit(1'b1);
    vec++;
    if (data_valid !== 1'b0) begin
      errs++;
      $display("FAIL ovr_drain: valid got %b expected 0", data_valid);
    end
    data_ready = 1'b0;
  endtask

  task automatic test_frame_err;
    int f0;
    f0 = ferr_seen;
    send_frame(8'h55, 1'b0);
    vec++;
    if (frame_err !== 1'b1 || data_valid !== 1'b0) begin
      errs++;
      $display("FAIL ferr_pulse: got ferr=%b valid=%b expected 1/0", frame_err, data_valid);
    end
    send_bit(1'b1);
    vec++;
    if (frame_err !== 1'b0 || ferr_seen - f0 != 1 || data_valid !== 1'b0) begin
      errs++;
      $display("FAIL ferr_once: got ferr=%b pulses=%0d valid=%b expected 0/1/0",
               frame_err, ferr_seen - f0, data_valid);
    end
    send_frame(8'h0F, 1'b1);
    vec++;
    if (data_out !== 8'h0F || data_valid !== 1'b1 || frame_err !== 1'b0) begin
      errs++;
      $display("FAIL ferr_recover: got %h/%b ferr=%b expected 0f/1/0",
               data_out, data_valid, frame_err);
    end
  endtask

  task automatic test_mid_reset;
    logic [11:0] obs;
    send_bit(LINE_START);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    send_bit(1'b1);
    obs = {data_out, data_valid, busy, frame_err, overrun};
    vec++;
    if (obs !== 12'h000) begin
      errs++;
      $display("FAIL midrst_outputs: got %h expected 000", obs);
    end
    rst = 1'b1;
    send_frame(8'h81, 1'b1);
    vec++;
    if (data_out !== 8'h81 || data_valid !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL midrst_next: got %h/%b busy=%b expected 81/1/0",
               data_out, data_valid, busy);
    end
    data_ready = 1'b1;
    send_bit(1'b1);
    data_ready = 1'b0;
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity;
    send_bit(LINE_START);
    send_body(8'h01, 1'b1, 1'b1);
    vec++;
    if (parity_err !== 1'b1 || data_valid !== 1'b0) begin
      errs++;
      $display("FAIL par_err: got perr=%b valid=%b expected 1/0", parity_err, data_valid);
    end
    send_bit(1'b1);
    vec++;
    if (parity_err !== 1'b0) begin
      errs++;
      $display("FAIL par_once: perr got %b expected 0", parity_err);
    end
    send_frame(8'h01, 1'b1);
    vec++;
    if (data_out !== 8'h01 || data_valid !== 1'b1 || parity_err !== 1'b0) begin
      errs++;
      $display("FAIL par_good: got %h/%b perr=%b expected 01/1/0",
               data_out, data_valid, parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_mid_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
